// File: rtl/banco_contadores_transicion_pkg.sv
// Shared defaults and helper for the transition-counter bank.
// Optional feature macro: PWR_CNT_SAT_EN (saturating counters; wrap when undefined).
package banco_contadores_transicion_pkg;

  localparam int NCH_DEF   = 4;
  localparam int W_DEF     = 8;
  localparam int CNT_W_DEF = 32;
  localparam int DIR_W_DEF = 2;

  // Bits needed to hold values 0..v-1; used to size the per-cycle toggle count.
  function automatic int clog2_f(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/banco_contadores_transicion_contador_canal.sv
// One channel of the transition-counter bank: previous-sample register, popcount of
// toggled bits, accumulator with overflow handling, clear muxing and sticky ovf.
// Optional feature macro: PWR_CNT_SAT_EN (saturate instead of wrap on overflow).
module contador_canal
  import banco_contadores_transicion_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             primed,
  input  logic             habilitar,
  input  logic             clr_canal,
  input  logic             clr_todo,
  input  logic [W-1:0]     senal,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam int INC_W = clog2_f(W + 1);

  logic [W-1:0]     prev;
  logic [W-1:0]     diff;
  logic [INC_W-1:0] inc;
  logic [CNT_W:0]   suma;
  logic [CNT_W-1:0] cnt_sig;

  assign diff = senal ^ prev;

  // Toggle count for this cycle; zero until the previous sample is valid or when held.
  always_comb begin
    inc = '0;
    if (primed && habilitar) begin
      for (int b = 0; b < W; b++) begin
        inc = inc + INC_W'(diff[b]);
      end
    end
  end

  // One extra bit so the carry out flags an overflow.
  assign suma = {1'b0, cnt} + (CNT_W + 1)'(inc);

`ifdef PWR_CNT_SAT_EN
  assign cnt_sig = suma[CNT_W] ? '1 : suma[CNT_W-1:0];
`else
  assign cnt_sig = suma[CNT_W-1:0];
`endif

  // Sample tracking and accumulation; a channel clear keeps this cycle's toggles.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      prev <= senal;
      if (clr_todo) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (clr_canal) begin
        cnt <= CNT_W'(inc);
        ovf <= 1'b0;
      end else begin
        cnt <= cnt_sig;
        ovf <= ovf | suma[CNT_W];
      end
    end
  end

endmodule

// File: rtl/banco_contadores_transicion.sv
// Transition-counter bank for power estimation: NCH channel counters plus a
// registered read port with optional read-and-clear.
// Optional feature macro: PWR_CNT_SAT_EN (saturating counters; wrap when undefined).
module banco_contadores_transicion
  import banco_contadores_transicion_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIR_W = DIR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             habilitar,
  input  logic [NCH*W-1:0] senal,
  input  logic             rd_req,
  input  logic [DIR_W-1:0] rd_dir,
  input  logic             rd_clr,
  input  logic             clr_todo,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_dato,
  output logic             rd_err,
  output logic [NCH-1:0]   ovf
);

  logic             primed;
  logic [31:0]      dir_ext;
  logic             dir_ok;
  logic [CNT_W-1:0] cnt_arr [NCH];
  logic [CNT_W-1:0] cnt_sel;

  assign dir_ext = 32'(rd_dir);
  assign dir_ok  = dir_ext < 32'(NCH);

  // The first cycle after reset only loads the previous-sample registers.
  always_ff @(posedge clk) begin
    if (reset) primed <= 1'b0;
    else       primed <= 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_canal
    logic clr_canal;
    assign clr_canal = rd_req && rd_clr && (dir_ext == 32'(i));

    contador_canal #(
      .W     (W),
      .CNT_W (CNT_W)
    ) u_canal (
      .clk       (clk),
      .reset     (reset),
      .primed    (primed),
      .habilitar (habilitar),
      .clr_canal (clr_canal),
      .clr_todo  (clr_todo),
      .senal     (senal[i*W +: W]),
      .cnt       (cnt_arr[i]),
      .ovf       (ovf[i])
    );
  end

  // Read mux; out-of-range addresses select zero.
  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (dir_ext == 32'(i)) cnt_sel = cnt_arr[i];
    end
  end

  // Registered read port: returns the counter as it stood before this cycle's update.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_dato  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      rd_err   <= rd_req && !dir_ok;
      rd_dato  <= (rd_req && dir_ok) ? cnt_sel : '0;
    end
  end

endmodule
